// File: rtl/tx_rd_req_tlp_gen_pkg.sv
// Shared definitions for the TX memory-read request generator: TLP
// fmt/type constants, FSM state encoding, Max_Read_Request_Size decode
// and MRd64 header beat assembly.
package tx_rd_req_tlp_gen_pkg;

    // 4DW header, no data, memory read
    localparam logic [6:0] FMT_TYPE_MRD64 = 7'b01_00000;
    // 3DW header, with data, completion (used by the completion path)
    localparam logic [6:0] FMT_TYPE_CPLD  = 7'b10_01010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_HDR0,
        ST_HDR1,
        ST_ACK,
        ST_DRAIN
    } state_t;

    // Per-request length in DW and number of requests needed per chunk
    typedef struct packed {
        logic [9:0] len_dw;
        logic [2:0] req_cnt;
    } mrrs_t;

    // Max_Read_Request_Size code -> request length and split count.
    // Codes above 256 B are capped at 512 B since a chunk is never larger.
    function automatic mrrs_t mrrs_decode(input logic [2:0] code, input int chunk_bytes);
        mrrs_t r;
        int    shift;
        case (code)
            3'b000:  begin r.len_dw = 10'd32;  shift = 7; end
            3'b001:  begin r.len_dw = 10'd64;  shift = 8; end
            default: begin r.len_dw = 10'd128; shift = 9; end
        endcase
        r.req_cnt = 3'(chunk_bytes >> shift);
        return r;
    endfunction

    // Beat 0: DW0 (fmt/type, TC/TD/EP/Attr zero, Length) and DW1
    // (requester ID, tag, both byte enables fully set).
    function automatic logic [63:0] mrd64_beat0(input logic [9:0]  len_dw,
                                                input logic [15:0] requester_id,
                                                input logic [7:0]  tag);
        return {1'b0, FMT_TYPE_MRD64, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len_dw,
                requester_id, tag, 4'hF, 4'hF};
    endfunction

    // Beat 1: 64-bit DW-aligned address
    function automatic logic [63:0] mrd64_beat1(input logic [63:0] addr);
        return {addr[63:32], addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/tx_rd_req_tlp_gen.sv
// Issues MRd64 request TLPs on the TRN TX interface for each 512 B chunk
// requested by the TX buffer writer, splitting by Max_Read_Request_Size
// and sending all splits back to back under a single arbiter grant.
module tx_rd_req_tlp_gen
    import tx_rd_req_tlp_gen_pkg::*;
#(
    parameter int CHUNK_BYTES = 512,
    parameter int TAG_BITS    = 5
) (
    input  logic        trn_clk,
    input  logic        reset,
    input  logic        read_chunk,
    input  logic [63:0] huge_page_addr_read_from,
    output logic        read_chunk_ack,
    input  logic [15:0] cfg_completer_id,
    input  logic [15:0] cfg_dcommand,
    output logic        tx_req,
    input  logic        tx_gnt,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n
);

    state_t              state;
    logic [63:0]         addr_q;
    logic [9:0]          len_dw_q;
    logic [2:0]          req_left;
    logic [TAG_BITS-1:0] tag_q;

    mrrs_t               mrrs_dec;
    logic [63:0]         addr_next;
    logic [TAG_BITS-1:0] tag_next;
    logic                unused_dcommand;

    assign mrrs_dec  = mrrs_decode(cfg_dcommand[14:12], CHUNK_BYTES);
    assign addr_next = addr_q + {52'd0, len_dw_q, 2'b00};
    assign tag_next  = tag_q + TAG_BITS'(1);

    // Only the MRRS field of the device command register matters here
    assign unused_dcommand = &{1'b0, cfg_dcommand[15], cfg_dcommand[11:0]};

    // Request FSM with all TRN outputs registered; beats hold under backpressure
    always_ff @(posedge trn_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            len_dw_q       <= '0;
            req_left       <= '0;
            tag_q          <= '0;
            tx_req         <= 1'b0;
            read_chunk_ack <= 1'b0;
            trn_td         <= '0;
            trn_trem_n     <= 8'h00;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read_chunk) begin
                        addr_q   <= huge_page_addr_read_from;
                        len_dw_q <= mrrs_dec.len_dw;
                        req_left <= mrrs_dec.req_cnt;
                        tx_req   <= 1'b1;
                        state    <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (tx_gnt) begin
                        trn_td         <= mrd64_beat0(len_dw_q, cfg_completer_id, 8'(tag_q));
                        trn_trem_n     <= 8'h00;
                        trn_tsof_n     <= 1'b0;
                        trn_teof_n     <= 1'b1;
                        trn_tsrc_rdy_n <= 1'b0;
                        state          <= ST_HDR0;
                    end
                end
                ST_HDR0: begin
                    if (!trn_tdst_rdy_n) begin
                        trn_td     <= mrd64_beat1(addr_q);
                        trn_tsof_n <= 1'b1;
                        trn_teof_n <= 1'b0;
                        state      <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (!trn_tdst_rdy_n) begin
                        addr_q     <= addr_next;
                        tag_q      <= tag_next;
                        req_left   <= req_left - 3'd1;
                        trn_teof_n <= 1'b1;
                        if (req_left != 3'd1) begin
                            // Next split request follows immediately under the same grant
                            trn_td     <= mrd64_beat0(len_dw_q, cfg_completer_id, 8'(tag_next));
                            trn_tsof_n <= 1'b0;
                            state      <= ST_HDR0;
                        end else begin
                            trn_td         <= '0;
                            trn_tsrc_rdy_n <= 1'b1;
                            read_chunk_ack <= 1'b1;
                            state          <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    read_chunk_ack <= 1'b0;
                    tx_req         <= 1'b0;
                    state          <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Upstream drops read_chunk in response to the ack; ignore it here
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_rd_req_tlp_gen.sv
// Self-checking bench for tx_rd_req_tlp_gen: a chunk-level reference model
// fills a scoreboard of expected TLPs, a monitor reconstructs TLPs from the
// TRN bus and compares them, and directed plus random chunks exercise
// splitting, backpressure, grant delay, tag wrap and reset abort.
module tb_tx_rd_req_tlp_gen;

    logic        trn_clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_chunk = 1'b0;
    logic [63:0] huge_page_addr_read_from = '0;
    logic        read_chunk_ack;
    logic [15:0] cfg_completer_id = 16'h0100;
    logic [15:0] cfg_dcommand = 16'h0000;
    logic        tx_req;
    logic        tx_gnt = 1'b1;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n = 1'b0;

    tx_rd_req_tlp_gen #(.CHUNK_BYTES(512), .TAG_BITS(5)) dut (
        .trn_clk                  (trn_clk),
        .reset                    (reset),
        .read_chunk               (read_chunk),
        .huge_page_addr_read_from (huge_page_addr_read_from),
        .read_chunk_ack           (read_chunk_ack),
        .cfg_completer_id         (cfg_completer_id),
        .cfg_dcommand             (cfg_dcommand),
        .tx_req                   (tx_req),
        .tx_gnt                   (tx_gnt),
        .trn_td                   (trn_td),
        .trn_trem_n               (trn_trem_n),
        .trn_tsof_n               (trn_tsof_n),
        .trn_teof_n               (trn_teof_n),
        .trn_tsrc_rdy_n           (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n           (trn_tdst_rdy_n)
    );

    // 100 MHz clock
    always #5 trn_clk = ~trn_clk;

    typedef struct {
        logic [63:0] beat0;
        logic [63:0] beat1;
    } tlp_t;

    tlp_t exp_q[$];
    int   chunk_rem_q[$];
    int   checks = 0;
    int   failures = 0;
    int   model_tag = 0;
    int   gnt_delay = 0;
    int   bp_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Reference model: split one chunk into the TLPs it should produce
    task automatic model_chunk(input logic [63:0] addr, input logic [15:0] dcmd, input logic [15:0] rid);
        int   n;
        int   bytes;
        tlp_t t;
        case (dcmd[14:12])
            3'b000:  n = 4;
            3'b001:  n = 2;
            default: n = 1;
        endcase
        bytes = 512 / n;
        for (int i = 0; i < n; i++) begin
            t.beat0 = {1'b0, 7'b0100000, 14'd0, 10'(bytes / 4), rid, 8'(model_tag), 8'hFF};
            t.beat1 = addr + 64'(i * bytes);
            exp_q.push_back(t);
            model_tag = (model_tag + 1) % 32;
        end
        chunk_rem_q.push_back(n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_req"}, tx_req, 0);
        check({tag, "_ack"}, read_chunk_ack, 0);
        check({tag, "_sof_eof_src"}, {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}, 3'b111);
        check({tag, "_td"}, trn_td, 64'd0);
        check({tag, "_trem"}, trn_trem_n, 8'h00);
    endtask

    // Arbiter model: grant either tied high or raised gnt_delay cycles after tx_req
    initial begin
        int gcnt;
        gcnt = 0;
        forever begin
            @(posedge trn_clk);
            #1;
            if (gnt_delay == 0) begin
                tx_gnt = 1'b1;
                gcnt   = 0;
            end else if (tx_req) begin
                gcnt++;
                tx_gnt = (gcnt > gnt_delay);
            end else begin
                gcnt   = 0;
                tx_gnt = 1'b0;
            end
        end
    end

    // Sink model: none, random, or scripted (3 cycles on beat 0, 2 on beat 1) backpressure
    initial begin
        int hold0;
        int hold1;
        hold0 = 0;
        hold1 = 0;
        forever begin
            @(posedge trn_clk);
            #1;
            if (bp_mode == 1) begin
                trn_tdst_rdy_n = ($urandom_range(0, 3) == 0);
            end else if (bp_mode == 2) begin
                if (!trn_tsrc_rdy_n && !trn_tsof_n && hold0 < 3) begin
                    trn_tdst_rdy_n = 1'b1;
                    hold0++;
                end else if (!trn_tsrc_rdy_n && !trn_teof_n && hold1 < 2) begin
                    trn_tdst_rdy_n = 1'b1;
                    hold1++;
                end else begin
                    trn_tdst_rdy_n = 1'b0;
                end
            end else begin
                trn_tdst_rdy_n = 1'b0;
            end
            if (!tx_req) begin
                hold0 = 0;
                hold1 = 0;
            end
        end
    end

    // Monitor: rebuild TLPs from transferred beats and compare against the scoreboard
    logic [63:0] b0_seen;
    bit          have_b0 = 0;
    bit          stall_prev = 0;
    logic [63:0] snap_td;
    logic [9:0]  snap_ctl;
    always @(negedge trn_clk) begin
        if (reset) begin
            have_b0    = 0;
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_td", trn_td, snap_td);
                check("stall_hold_ctl", {trn_trem_n, trn_tsof_n, trn_teof_n}, snap_ctl);
            end
            if (!trn_tsrc_rdy_n)
                check("data_only_with_grant", {tx_req, tx_gnt}, 2'b11);
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                if (!trn_tsof_n) begin
                    check("beat0_framing", {trn_trem_n, trn_teof_n}, {8'h00, 1'b1});
                    b0_seen = trn_td;
                    have_b0 = 1;
                end else if (!trn_teof_n) begin
                    if (!have_b0) begin
                        fail_now("beat1_without_beat0");
                    end else if (exp_q.size() == 0) begin
                        fail_now("unexpected_tlp");
                    end else begin
                        tlp_t e;
                        e = exp_q.pop_front();
                        check("tlp_beat0", b0_seen, e.beat0);
                        check("tlp_beat1", trn_td, e.beat1);
                        check("beat1_trem", trn_trem_n, 8'h00);
                        if (chunk_rem_q.size() > 0)
                            chunk_rem_q[0] = chunk_rem_q[0] - 1;
                    end
                    have_b0 = 0;
                end else begin
                    fail_now("beat_without_sof_or_eof");
                end
            end
            if (read_chunk_ack) begin
                if (chunk_rem_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    check("ack_after_last_tlp", 64'(chunk_rem_q[0]), 64'd0);
                    void'(chunk_rem_q.pop_front());
                end
            end
            stall_prev = !trn_tsrc_rdy_n && trn_tdst_rdy_n;
            snap_td    = trn_td;
            snap_ctl   = {trn_trem_n, trn_tsof_n, trn_teof_n};
        end
    end

    // Issue one chunk request and wait for its ack; optionally check ack latency
    task automatic run_chunk(input string name, input logic [63:0] addr, input logic [15:0] dcmd,
                             input logic [15:0] rid, input int gdly, input int bpm,
                             input bit late, input int exp_lat);
        int lat;
        bit got;
        bit req_dropped;
        cfg_dcommand     = dcmd;
        cfg_completer_id = rid;
        gnt_delay        = gdly;
        bp_mode          = bpm;
        model_chunk(addr, dcmd, rid);
        @(posedge trn_clk);
        #1;
        read_chunk               = 1'b1;
        huge_page_addr_read_from = addr;
        lat         = 0;
        got         = 0;
        req_dropped = 0;
        while (!got && lat < 400) begin
            @(posedge trn_clk);
            #1;
            lat++;
            if (read_chunk_ack)
                got = 1;
            else if (!tx_req)
                req_dropped = 1;
            // Register changes mid-chunk must not affect the chunk in flight
            if (lat == 2)
                cfg_dcommand = 16'($urandom);
        end
        check({name, "_ack_seen"}, got, 1);
        check({name, "_tx_req_held"}, req_dropped, 0);
        if (exp_lat >= 0)
            check({name, "_ack_latency"}, 64'(lat), 64'(exp_lat));
        if (late) begin
            // Keep read_chunk high through the drain cycle; it must be ignored
            repeat (2) @(posedge trn_clk);
            #1;
        end
        read_chunk = 1'b0;
        repeat (2) @(posedge trn_clk);
        #1;
        check({name, "_tx_req_released"}, tx_req, 0);
    endtask

    initial begin
        bit got;
        logic [63:0] a;

        repeat (3) @(posedge trn_clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge trn_clk);
        #1;
        check_reset_outputs("idle");

        // Single 512 B request, grant tied high, no backpressure
        run_chunk("mrrs512", 64'h0000_0001_2345_6000, 16'h2000, 16'h0100, 0, 0, 0, 4);
        // Four 128 B requests
        run_chunk("mrrs128", 64'h0000_0000_0000_1000, 16'h0000, 16'h0100, 0, 0, 0, 10);
        // Scripted backpressure on both beats: ack delayed by 5 cycles
        run_chunk("backpressure", 64'h0000_00AB_CDEF_0200, 16'h2000, 16'h0100, 0, 2, 0, 9);
        // Grant withheld for 10 cycles, two 256 B requests
        run_chunk("gnt_delay", 64'h0000_0000_8000_0400, 16'h1000, 16'h0100, 10, 0, 0, 16);
        // A drain-cycle read_chunk is ignored
        run_chunk("late_drop", 64'h0000_0000_0000_3E00, 16'h5000, 16'h0100, 0, 0, 1, 4);

        // Reset in the middle of the first TLP's beat 1
        cfg_dcommand     = 16'h0000;
        cfg_completer_id = 16'h0100;
        gnt_delay        = 0;
        bp_mode          = 0;
        model_chunk(64'h0000_0000_0000_2000, 16'h0000, 16'h0100);
        @(posedge trn_clk);
        #1;
        read_chunk               = 1'b1;
        huge_page_addr_read_from = 64'h0000_0000_0000_2000;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge trn_clk);
            #1;
            if (!trn_teof_n && !trn_tsrc_rdy_n)
                got = 1;
        end
        check("abort_reached_hdr1", got, 1);
        reset      = 1'b1;
        read_chunk = 1'b0;
        @(posedge trn_clk);
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        chunk_rem_q.delete();
        model_tag = 0;
        @(posedge trn_clk);
        #1;
        reset = 1'b0;

        // Nine 4-way chunks after the abort: tags 0..31 then wrap to 0..3
        for (int k = 0; k < 9; k++)
            run_chunk("wrap", 64'h0000_0000_0010_0000 + 64'(k * 512), 16'h0000, 16'h0100, 0, 0, 0, 10);

        // Random chunks with random MRRS, requester ID, grant delay and backpressure
        for (int k = 0; k < 10; k++) begin
            a      = {$urandom, $urandom};
            a[8:0] = 9'd0;
            run_chunk("random", a, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1,
                      1'($urandom_range(0, 1)), -1);
        end

        bp_mode = 0;
        repeat (4) @(posedge trn_clk);
        #1;
        check("all_tlps_delivered", 64'(exp_q.size()), 64'd0);
        check("all_chunks_acked", 64'(chunk_rem_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
